// File: rtl/tick_sched.sv
// tick_sched: programmable tick scheduler.
//
// A divide ratio (and, optionally, a burst length) is loaded through a
// valid/ready handshake while idle. On start the prescale counter runs and
// produces a one-cycle tick plus a half-duty square wave every div_q cycles,
// until stop is seen or (with bursts enabled) the programmed tick count
// has been emitted.
//
// Optional feature macro: TICK_SCHED_BURST_EN
//   defined   - cfg_burst != 0 ends the run automatically after that many ticks
//   undefined - cfg_burst is ignored, every run free-runs until stop
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   start      begin a run (sampled in IDLE only)
//   stop       end a run (sampled in RUN only)
//   cfg_valid  configuration offered
//   cfg_ready  configuration accepted this cycle (state == IDLE)
//   cfg_div    divide ratio in cycles per tick, 0 is treated as 1
//   cfg_burst  ticks per run, 0 = free-run
//   tick       one-cycle strobe once per period
//   half       square wave, low for floor(div/2) cycles from each tick
//   busy       state != IDLE
//   done       one-cycle pulse when a run finishes
module tick_sched #(
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_burst,
  output logic             tick,
  output logic             half,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_eff;
  logic             tick_d, half_d, done_d;
  logic             cfg_take;
  logic             wrap;
  logic             burst_end;

`ifdef TICK_SCHED_BURST_EN
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] left, left_d;
`else
  logic             unused_burst;
  assign unused_burst = ^cfg_burst;
`endif

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    div_d     = div_q;
    tick_d    = 1'b0;
    half_d    = 1'b0;
    done_d    = 1'b0;
    burst_end = 1'b0;
`ifdef TICK_SCHED_BURST_EN
    burst_d   = burst_q;
    left_d    = left;
`endif

    cfg_take = cfg_valid && (state == IDLE);
    div_eff  = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    wrap     = (cnt == div_q - DIV_W'(1));

    // A config accepted in the same cycle as start must already govern the
    // starting run, so everything below uses the *_d copies.
    if (cfg_take) begin
      div_d = div_eff;
`ifdef TICK_SCHED_BURST_EN
      burst_d = cfg_burst;
`endif
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          // half tracks the counter value that will be held after this edge.
          half_d  = ((div_d >> 1) == '0);
`ifdef TICK_SCHED_BURST_EN
          left_d  = burst_d;
`endif
        end
      end

      RUN: begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d  = cnt + DIV_W'(1);
        end
`ifdef TICK_SCHED_BURST_EN
        if (wrap && (burst_q != '0)) begin
          left_d = left - CNT_W'(1);
          if (left == CNT_W'(1)) begin
            burst_end = 1'b1;
          end
        end
`endif
        // A wrap coinciding with the end of the run still emits its tick.
        if (stop || burst_end) begin
          state_d = FINISH;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          half_d  = (cnt_d >= (div_q >> 1));
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= DIV_W'(DIV_RST);
      tick    <= 1'b0;
      half    <= 1'b0;
      done    <= 1'b0;
`ifdef TICK_SCHED_BURST_EN
      burst_q <= '0;
      left    <= '0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      div_q   <= div_d;
      tick    <= tick_d;
      half    <= half_d;
      done    <= done_d;
`ifdef TICK_SCHED_BURST_EN
      burst_q <= burst_d;
      left    <= left_d;
`endif
    end
  end

endmodule

// File: tb/tb_tick_sched.sv
// Testbench for tick_sched: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model that predicts the
// outputs from the number of cycles elapsed since the start edge.
module tb_tick_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_burst;
  logic        tick;
  logic        half;
  logic        busy;
  logic        done;

  int checkCount;
  int failCount;

  // Reference model: phase 0 idle, 1 run, 2 finish; mK counts edges since start.
  int mState;
  int mDiv;
  int mBurst;
  int mLeft;
  int mK;
  logic eTick;
  logic eHalf;
  logic eDone;

  tick_sched #(
    .DIV_W  (16),
    .CNT_W  (8),
    .DIV_RST(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_burst(cfg_burst),
    .tick     (tick),
    .half     (half),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mState = 0;
    mDiv   = 16;
    mBurst = 0;
    mLeft  = 0;
    mK     = 0;
    eTick  = 1'b0;
    eHalf  = 1'b0;
    eDone  = 1'b0;
  endtask

  task automatic compareAll();
    checkOutput("tick", {31'd0, tick}, {31'd0, eTick});
    checkOutput("half", {31'd0, half}, {31'd0, eHalf});
    checkOutput("done", {31'd0, done}, {31'd0, eDone});
    checkOutput("busy", {31'd0, busy}, {31'd0, (mState != 0)});
    checkOutput("cfg_ready", {31'd0, cfg_ready}, {31'd0, (mState == 0)});
  endtask

  // Drives one cycle of inputs (called just after an edge), advances the
  // model for the coming edge, then compares all outputs after that edge.
  task automatic applyStimulus(input logic s, input logic sp, input logic cv,
                               input int cd, input int cb);
    bit fin;
    start     = s;
    stop      = sp;
    cfg_valid = cv;
    cfg_div   = 16'(cd);
    cfg_burst = 8'(cb);
    eTick = 1'b0;
    eHalf = 1'b0;
    eDone = 1'b0;
    case (mState)
      0: begin
        if (cv) begin
          mDiv   = (cd == 0) ? 1 : cd;
          mBurst = cb;
        end
        if (s) begin
          mState = 1;
          mK     = 0;
          mLeft  = mBurst;
          eHalf  = ((mDiv / 2) == 0);
        end
      end
      1: begin
        mK++;
        eTick = ((mK % mDiv) == 0);
        fin   = sp;
`ifdef TICK_SCHED_BURST_EN
        if (eTick && mBurst != 0) begin
          mLeft--;
          if (mLeft == 0) fin = 1'b1;
        end
`endif
        if (fin) begin
          mState = 2;
          eDone  = 1'b1;
        end else begin
          eHalf = ((mK % mDiv) >= (mDiv / 2));
        end
      end
      default: begin
        mState = 0;
      end
    endcase
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  // Starts a run with the current config and reports the first tick edge.
  task automatic measureFirstTick(input int span, output int firstAt);
    firstAt = 0;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i <= span; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (tick && firstAt == 0) firstAt = i;
    end
  endtask

  initial begin
    int n;
    int cnt;
    checkCount = 0;
    failCount  = 0;
    rst       = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_burst = '0;
    modelReset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tick", {31'd0, tick}, 32'd0);
    checkOutput("rst_half", {31'd0, half}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b1;
    idleCycles(2);

    // Default divide ratio after reset
    $display("[TB] default ratio run");
    measureFirstTick(40, n);
    checkOutput("first_tick_default", n, 16);
    applyStimulus(0, 1, 0, 0, 0);
    idleCycles(1);

    // div=5: half low 2 cycles, high 3 per period
    $display("[TB] div=5 run");
    applyStimulus(0, 0, 1, 5, 0);
    applyStimulus(1, 0, 0, 0, 0);
    cnt = half ? 1 : 0;
    for (int i = 1; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (half) cnt++;
    end
    checkOutput("half_high_div5", cnt, 3);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tick_at_5", {31'd0, tick}, 32'd1);
    // config offered during RUN is held off until IDLE
    applyStimulus(0, 0, 1, 9, 0);
    checkOutput("ready_in_run", {31'd0, cfg_ready}, 32'd0);
    applyStimulus(0, 1, 1, 9, 0);
    applyStimulus(0, 0, 1, 9, 0);
    applyStimulus(0, 0, 1, 9, 0);
    measureFirstTick(12, n);
    checkOutput("first_tick_div9", n, 9);
    applyStimulus(0, 1, 0, 0, 0);
    idleCycles(1);

    // div=0 clamps to 1, config and start in the same cycle
    $display("[TB] div=0 run");
    applyStimulus(1, 0, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (tick && half) cnt++;
    end
    checkOutput("div1_tick_half", cnt, 6);
    applyStimulus(0, 1, 0, 0, 0);
    idleCycles(1);

    // Burst of 3 ticks at div=4
    $display("[TB] burst run");
    applyStimulus(1, 0, 1, 4, 3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (tick) cnt++;
    end
`ifdef TICK_SCHED_BURST_EN
    checkOutput("burst_ticks", cnt, 3);
`else
    checkOutput("burst_ticks", cnt, 5);
    applyStimulus(0, 1, 0, 0, 0);
    idleCycles(1);
`endif

    // Stop on the wrap cycle, then stop mid-period, at div=8 free-run
    $display("[TB] stop timing");
    applyStimulus(1, 0, 1, 8, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("stop_wrap_tick", {31'd0, tick}, 32'd1);
    checkOutput("stop_wrap_done", {31'd0, done}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("finish_to_idle", {31'd0, busy}, 32'd0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("start_stop_idle", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("stop_mid_tick", {31'd0, tick}, 32'd0);
    checkOutput("stop_mid_done", {31'd0, done}, 32'd1);
    idleCycles(1);

    // Asynchronous reset in the middle of a run
    $display("[TB] reset mid-run");
    applyStimulus(1, 0, 1, 6, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_tick", {31'd0, tick}, 32'd0);
    checkOutput("mid_rst_half", {31'd0, half}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
    modelReset();
    @(posedge clk);
    #1;
    compareAll();
    rst = 1'b1;
    measureFirstTick(20, n);
    checkOutput("first_tick_after_rst", n, 16);
    applyStimulus(0, 1, 0, 0, 0);
    idleCycles(1);

    // Randomized traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 30) == 0,
                    $urandom_range(0, 3) == 0, int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
